// File: rtl/pow_pkg.sv
// Shared types and defaults for the power-engine dispatcher.
// Holds the dispatcher state encoding, default operand widths and the
// packed request record {x, n} used when building job tables.
package pow_pkg;

  localparam int XW_DEF = 16;
  localparam int NW_DEF = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } state_e;

  typedef struct packed {
    logic [XW_DEF-1:0] x;
    logic [NW_DEF-1:0] n;
  } req_t;

endpackage

// File: rtl/pow_dispatch_if.sv
// Request/result streams of the power dispatcher.
// slave  : dispatcher side (consumes in_*, produces out_*).
// master : producer/consumer side (drives in_* and out_ready).
interface pow_dispatch_if
  import pow_pkg::*;
#(
  parameter int XW = XW_DEF,
  parameter int NW = NW_DEF
) ();

  logic          in_valid;
  logic          in_ready;
  logic [XW-1:0] in_x;
  logic [NW-1:0] in_n;

  logic          out_valid;
  logic          out_ready;
  logic [XW-1:0] out_res;
  logic [XW-1:0] out_x;
  logic [NW-1:0] out_n;

  modport master (
    output in_valid, in_x, in_n, out_ready,
    input  in_ready, out_valid, out_res, out_x, out_n
  );

  modport slave (
    input  in_valid, in_x, in_n, out_ready,
    output in_ready, out_valid, out_res, out_x, out_n
  );

endinterface

// File: rtl/pow_req_fifo.sv
// Request queue: DEPTH x W storage, power-of-two depth, pointers wrap naturally.
// Latency: a push is visible at the head on the following cycle (no bypass).
// Backpressure: push ignored when full, pop ignored when empty; count_o = occupancy.
// Ports: clk, rst (sync, active-high); push_i/push_dat_i; pop_i/pop_dat_o;
//        full_o, empty_o, count_o.
module pow_req_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 24
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push_i,
  input  logic [W-1:0]             push_dat_i,
  input  logic                     pop_i,
  output logic [W-1:0]             pop_dat_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   count_o
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q;
  logic [AW-1:0] rd_ptr_q;
  logic [AW:0]   count_q;
  logic          do_push;
  logic          do_pop;

  assign full_o    = (count_q == FULL_CNT);
  assign empty_o   = (count_q == '0);
  assign count_o   = count_q;
  assign pop_dat_o = mem_q[rd_ptr_q];
  assign do_push   = push_i && !full_o;
  assign do_pop    = pop_i && !empty_o;

  // Storage needs no reset: only entries below count_q are ever read.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= push_dat_i;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/pow_dispatch.sv
// Feeds queued (x, n) jobs one at a time to the power engine and returns results in order.
// Latency: empty queue + idle engine -> out_valid after 3 cycles + engine busy cycles.
// Backpressure: in_ready = queue not full; result held stable until out_ready, no new launch meanwhile.
// Ports: clk, rst (sync, active-high); bus (request/result streams, slave side);
//        eng_start/eng_inx/eng_inn/eng_ready/eng_out (engine); pending (queue occupancy);
//        err (sticky engine timeout).
module pow_dispatch
  import pow_pkg::*;
#(
  parameter int DEPTH   = 4,
  parameter int XW      = XW_DEF,
  parameter int NW      = NW_DEF,
  parameter int TIMEOUT = 64
) (
  input  logic                   clk,
  input  logic                   rst,
  pow_dispatch_if.slave          bus,
  output logic                   eng_start,
  output logic [XW-1:0]          eng_inx,
  output logic [NW-1:0]          eng_inn,
  input  logic                   eng_ready,
  input  logic [XW-1:0]          eng_out,
  output logic [$clog2(DEPTH):0] pending,
  output logic                   err
);

  localparam int CW = $clog2(TIMEOUT+1);
  localparam logic [CW-1:0] LAST_WAIT = CW'(TIMEOUT-1);

  state_e        state_q, state_d;
  logic [XW-1:0] eng_inx_q, eng_inx_d;
  logic [NW-1:0] eng_inn_q, eng_inn_d;
  logic          out_valid_q, out_valid_d;
  logic [XW-1:0] out_res_q, out_res_d;
  logic [XW-1:0] out_x_q, out_x_d;
  logic [NW-1:0] out_n_q, out_n_d;
  logic          err_q, err_d;
  logic [CW-1:0] wait_cnt_q, wait_cnt_d;

  logic             fifo_pop;
  logic             fifo_full;
  logic             fifo_empty;
  logic [XW+NW-1:0] fifo_head;

  pow_req_fifo #(
    .DEPTH (DEPTH),
    .W     (XW+NW)
  ) u_fifo (
    .clk        (clk),
    .rst        (rst),
    .push_i     (bus.in_valid),
    .push_dat_i ({bus.in_x, bus.in_n}),
    .pop_i      (fifo_pop),
    .pop_dat_o  (fifo_head),
    .full_o     (fifo_full),
    .empty_o    (fifo_empty),
    .count_o    (pending)
  );

  assign bus.in_ready  = !fifo_full;
  assign bus.out_valid = out_valid_q;
  assign bus.out_res   = out_res_q;
  assign bus.out_x     = out_x_q;
  assign bus.out_n     = out_n_q;
  // The launch pulse is a pure state decode: ISSUE lasts exactly one cycle.
  assign eng_start     = (state_q == ISSUE);
  assign eng_inx       = eng_inx_q;
  assign eng_inn       = eng_inn_q;
  assign err           = err_q;

  always_comb begin
    state_d     = state_q;
    eng_inx_d   = eng_inx_q;
    eng_inn_d   = eng_inn_q;
    out_valid_d = out_valid_q;
    out_res_d   = out_res_q;
    out_x_d     = out_x_q;
    out_n_d     = out_n_q;
    err_d       = err_q;
    wait_cnt_d  = wait_cnt_q;
    fifo_pop    = 1'b0;
    case (state_q)
      IDLE: begin
        // Launch only into an idle engine so start never meets a busy engine.
        if (!fifo_empty && eng_ready) begin
          fifo_pop  = 1'b1;
          eng_inx_d = fifo_head[XW+NW-1:NW];
          eng_inn_d = fifo_head[NW-1:0];
          state_d   = ISSUE;
        end
      end
      ISSUE: begin
        wait_cnt_d = '0;
        state_d    = WAIT;
      end
      WAIT: begin
        wait_cnt_d = wait_cnt_q + 1'b1;
        if (eng_ready) begin
          out_res_d   = eng_out;
          out_x_d     = eng_inx_q;
          out_n_d     = eng_inn_q;
          out_valid_d = 1'b1;
          state_d     = RESP;
        end else if (wait_cnt_q == LAST_WAIT) begin
          // TIMEOUT-th cycle in WAIT without a result: give up with a zero result.
          err_d       = 1'b1;
          out_res_d   = '0;
          out_x_d     = eng_inx_q;
          out_n_d     = eng_inn_q;
          out_valid_d = 1'b1;
          state_d     = RESP;
        end
      end
      RESP: begin
        if (bus.out_ready) begin
          out_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      eng_inx_q   <= '0;
      eng_inn_q   <= '0;
      out_valid_q <= 1'b0;
      out_res_q   <= '0;
      out_x_q     <= '0;
      out_n_q     <= '0;
      err_q       <= 1'b0;
      wait_cnt_q  <= '0;
    end else begin
      state_q     <= state_d;
      eng_inx_q   <= eng_inx_d;
      eng_inn_q   <= eng_inn_d;
      out_valid_q <= out_valid_d;
      out_res_q   <= out_res_d;
      out_x_q     <= out_x_d;
      out_n_q     <= out_n_d;
      err_q       <= err_d;
      wait_cnt_q  <= wait_cnt_d;
    end
  end

endmodule

// File: tb/tb_pow_dispatch.sv
// Bench for pow_dispatch driving a behavioural square-and-multiply engine.
// Stimulus pushes jobs and queues hand-computed results; a monitor pops and compares.
// Inputs change on the falling edge; the monitor samples shortly after it.
module tb_pow_dispatch;
  import pow_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        eng_start;
  logic [15:0] eng_inx;
  logic [7:0]  eng_inn;
  logic        eng_ready;
  logic [15:0] eng_out;
  logic [2:0]  pending;
  logic        err;

  pow_dispatch_if #(.XW(16), .NW(8)) bus ();

  pow_dispatch #(.DEPTH(4), .XW(16), .NW(8), .TIMEOUT(64)) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus),
    .eng_start (eng_start),
    .eng_inx   (eng_inx),
    .eng_inn   (eng_inn),
    .eng_ready (eng_ready),
    .eng_out   (eng_out),
    .pending   (pending),
    .err       (err)
  );

  always #5 clk = ~clk;

  // ---------------- behavioural engine ----------------
  int          e_cnt;
  logic        e_hang;
  logic        stuck_mode = 1'b0;
  logic [15:0] e_res;

  function automatic logic [15:0] powm(input logic [15:0] x, input logic [7:0] n);
    logic [31:0] t;
    logic [15:0] r;
    r = 16'd1;
    for (int i = 7; i >= 0; i--) begin
      t = r * r;
      r = t[15:0];
      if (n[i]) begin
        t = r * x;
        r = t[15:0];
      end
    end
    return r;
  endfunction

  function automatic int busy_of(input logic [7:0] n);
    int b;
    b = 1;
    for (int i = 0; i < 8; i++) if (n[i]) b = i + 1;
    return b;
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      e_cnt  <= 0;
      e_hang <= 1'b0;
      e_res  <= '0;
    end else if (eng_start && eng_ready) begin
      e_res <= powm(eng_inx, eng_inn);
      e_cnt <= busy_of(eng_inn);
      if (stuck_mode) e_hang <= 1'b1;
    end else if (e_cnt > 0) begin
      e_cnt <= e_cnt - 1;
    end
  end

  assign eng_ready = (e_cnt == 0) && !e_hang;
  assign eng_out   = e_res;

  // ---------------- scoreboard ----------------
  typedef struct {
    logic [15:0] res;
    logic [15:0] x;
    logic [7:0]  n;
    bit          chk_xn;
  } exp_t;

  exp_t sb_q[$];
  int   checks    = 0;
  int   failures  = 0;
  int   hs_cnt    = 0;
  int   start_cnt = 0;

  task automatic chk(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      failures++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, req, $time);
    end
  endtask

  always @(negedge clk) begin
    #2;
    if (!rst) begin
      if (eng_start) begin
        start_cnt++;
        chk("start_while_busy", int'(eng_ready), 1);
      end
      if (bus.out_valid && bus.out_ready) begin
        hs_cnt++;
        if (sb_q.size() == 0) begin
          chk("unexpected_result", int'(bus.out_res), -1);
        end else begin
          exp_t e;
          e = sb_q.pop_front();
          chk("out_res", int'(bus.out_res), int'(e.res));
          if (e.chk_xn) begin
            chk("out_x", int'(bus.out_x), int'(e.x));
            chk("out_n", int'(bus.out_n), int'(e.n));
          end
        end
      end
    end
  end

  // ---------------- stimulus helpers (called on a falling edge) ----------------
  task automatic push(input logic [15:0] x, input logic [7:0] n, input logic [15:0] res,
                      input bit track, input bit chk_xn);
    int k;
    exp_t e;
    bus.in_valid = 1'b1;
    bus.in_x     = x;
    bus.in_n     = n;
    k = 0;
    while (!bus.in_ready && k < 300) begin
      @(negedge clk);
      k++;
    end
    if (!bus.in_ready) begin
      chk("push_accept_timeout", 0, 1);
    end else begin
      @(negedge clk);
      if (track) begin
        e.res = res; e.x = x; e.n = n; e.chk_xn = chk_xn;
        sb_q.push_back(e);
      end
    end
    bus.in_valid = 1'b0;
  endtask

  task automatic wait_drain();
    int k;
    k = 0;
    while ((sb_q.size() != 0 || bus.out_valid) && k < 1000) begin
      @(negedge clk);
      k++;
    end
    chk("drain_left", sb_q.size(), 0);
  endtask

  req_t        b2b_v[4]  = '{'{16'd2, 8'd10}, '{16'd5, 8'd3}, '{16'd7, 8'd0}, '{16'd300, 8'd2}};
  logic [15:0] b2b_r[4]  = '{16'd1024, 16'd125, 16'd1, 16'd24464};
  req_t        st_v[6]   = '{'{16'd3, 8'd5}, '{16'd2, 8'd7}, '{16'd10, 8'd4},
                             '{16'd255, 8'd2}, '{16'd6, 8'd6}, '{16'd2, 8'd15}};
  logic [15:0] st_r[6]   = '{16'd243, 16'd128, 16'd10000, 16'd65025, 16'd46656, 16'd32768};
  req_t        wr_v[10]  = '{'{16'd1, 8'd5}, '{16'd2, 8'd3}, '{16'd3, 8'd3}, '{16'd4, 8'd4},
                             '{16'd5, 8'd5}, '{16'd6, 8'd2}, '{16'd7, 8'd3}, '{16'd8, 8'd4},
                             '{16'd9, 8'd4}, '{16'd11, 8'd2}};
  logic [15:0] wr_r[10]  = '{16'd1, 16'd8, 16'd27, 16'd256, 16'd3125, 16'd36, 16'd343,
                             16'd4096, 16'd6561, 16'd121};

  initial begin
    int k;
    int s0;
    int h0;
    bus.in_valid  = 1'b0;
    bus.in_x      = '0;
    bus.in_n      = '0;
    bus.out_ready = 1'b0;
    repeat (3) @(negedge clk);

    // reset state, sampled while rst is still held
    chk("rst_in_ready", int'(bus.in_ready), 1);
    chk("rst_out_valid", int'(bus.out_valid), 0);
    chk("rst_out_res", int'(bus.out_res), 0);
    chk("rst_out_x", int'(bus.out_x), 0);
    chk("rst_out_n", int'(bus.out_n), 0);
    chk("rst_eng_start", int'(eng_start), 0);
    chk("rst_eng_inx", int'(eng_inx), 0);
    chk("rst_eng_inn", int'(eng_inn), 0);
    chk("rst_pending", int'(pending), 0);
    chk("rst_err", int'(err), 0);
    rst = 1'b0;
    @(negedge clk);

    // single job 3^4
    bus.out_ready = 1'b1;
    s0 = start_cnt;
    h0 = hs_cnt;
    push(16'd3, 8'd4, 16'd81, 1'b1, 1'b1);
    wait_drain();
    repeat (3) @(negedge clk);
    chk("single_start_pulses", start_cnt - s0, 1);
    chk("single_valid_pulses", hs_cnt - h0, 1);

    // back-to-back jobs
    for (int i = 0; i < 4; i++) push(b2b_v[i].x, b2b_v[i].n, b2b_r[i], 1'b1, 1'b1);
    wait_drain();

    // consumer stall: 1 in flight + 4 queued, sixth waits
    bus.out_ready = 1'b0;
    for (int i = 0; i < 5; i++) push(st_v[i].x, st_v[i].n, st_r[i], 1'b1, 1'b1);
    chk("stall_pending", int'(pending), 4);
    chk("stall_in_ready", int'(bus.in_ready), 0);
    fork
      push(st_v[5].x, st_v[5].n, st_r[5], 1'b1, 1'b1);
      begin
        k = 0;
        while (!bus.out_valid && k < 200) begin
          @(negedge clk);
          k++;
        end
        chk("stall_first_valid", int'(bus.out_valid), 1);
        repeat (4) begin
          @(negedge clk);
          chk("stall_hold_valid", int'(bus.out_valid), 1);
          chk("stall_hold_res", int'(bus.out_res), 243);
          chk("stall_hold_x", int'(bus.out_x), 3);
          chk("stall_hold_n", int'(bus.out_n), 5);
          chk("stall_hold_in_ready", int'(bus.in_ready), 0);
        end
        bus.out_ready = 1'b1;
      end
    join
    wait_drain();

    // simultaneous push and pop at pending=2
    bus.out_ready = 1'b0;
    push(16'd4, 8'd2, 16'd16, 1'b1, 1'b1);
    push(16'd5, 8'd2, 16'd25, 1'b1, 1'b1);
    push(16'd6, 8'd2, 16'd36, 1'b1, 1'b1);
    k = 0;
    while (!bus.out_valid && k < 200) begin
      @(negedge clk);
      k++;
    end
    chk("pp_pre_pending", int'(pending), 2);
    bus.out_ready = 1'b1;
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.in_x     = 16'd7;
    bus.in_n     = 8'd2;
    chk("pp_idle_pending", int'(pending), 2);
    @(negedge clk);
    sb_q.push_back('{res: 16'd49, x: 16'd7, n: 8'd2, chk_xn: 1'b1});
    bus.in_valid = 1'b0;
    chk("pp_after_pending", int'(pending), 2);
    chk("pp_after_start", int'(eng_start), 1);
    wait_drain();

    // ten jobs through the queue, pointers wrap several times by now
    for (int i = 0; i < 10; i++) push(wr_v[i].x, wr_v[i].n, wr_r[i], 1'b1, 1'b1);
    wait_drain();

    // reset during WAIT with two queued; in-flight result discarded
    push(16'd2, 8'd255, 16'd0, 1'b0, 1'b0);
    push(16'd3, 8'd1, 16'd0, 1'b0, 1'b0);
    push(16'd5, 8'd1, 16'd0, 1'b0, 1'b0);
    chk("mid_rst_pending_before", int'(pending), 2);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("mid_rst_out_valid", int'(bus.out_valid), 0);
    chk("mid_rst_pending", int'(pending), 0);
    chk("mid_rst_in_ready", int'(bus.in_ready), 1);
    chk("mid_rst_eng_start", int'(eng_start), 0);
    push(16'd4, 8'd3, 16'd64, 1'b1, 1'b1);
    wait_drain();

    // engine never returns: timeout after 64 WAIT cycles
    stuck_mode = 1'b1;
    push(16'd7, 8'd2, 16'd0, 1'b1, 1'b0);
    k = 0;
    while (!eng_start && k < 20) begin
      @(negedge clk);
      k++;
    end
    chk("to_start_seen", int'(eng_start), 1);
    chk("to_err_before", int'(err), 0);
    k = 0;
    while (!bus.out_valid && k < 200) begin
      @(negedge clk);
      k++;
    end
    chk("to_cycles", k, 65);
    chk("to_err_set", int'(err), 1);
    chk("to_res_zero", int'(bus.out_res), 0);
    @(negedge clk);
    @(negedge clk);
    chk("to_valid_cleared", int'(bus.out_valid), 0);
    chk("to_err_sticky", int'(err), 1);
    wait_drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    failures++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

endmodule
